// File: rtl/core_pkg.sv
// Shared definitions for the multicycle core: opcodes, FSM state encoding
// and instruction field helpers (fields are handled as 64-bit containers).
package core_pkg;

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_AND  = 4'h2;
  localparam logic [3:0] OP_OR   = 4'h3;
  localparam logic [3:0] OP_XOR  = 4'h4;
  localparam logic [3:0] OP_SLT  = 4'h5;
  localparam logic [3:0] OP_ADDI = 4'h6;
  localparam logic [3:0] OP_LI   = 4'h7;
  localparam logic [3:0] OP_LW   = 4'hA;
  localparam logic [3:0] OP_SW   = 4'hB;
  localparam logic [3:0] OP_BEQ  = 4'hC;
  localparam logic [3:0] OP_BNE  = 4'hD;
  localparam logic [3:0] OP_J    = 4'hE;
  localparam logic [3:0] OP_HALT = 4'hF;

  typedef enum logic [2:0] {
    ST_FETCH,
    ST_DECODE,
    ST_EXEC,
    ST_MEM,
    ST_WB,
    ST_HALT
  } state_t;

  function automatic logic [63:0] get_field(input logic [63:0] word, input int lsb, input int width);
    return (word >> lsb) & ~(64'hFFFF_FFFF_FFFF_FFFF << width);
  endfunction

  function automatic logic [63:0] sext(input logic [63:0] value, input int width);
    logic [63:0] upper;
    upper = 64'hFFFF_FFFF_FFFF_FFFF << width;
    if (((value >> (width - 1)) & 64'd1) != 64'd0) return value | upper;
    return value & ~upper;
  endfunction

endpackage

// File: rtl/multicycle_core_regfile.sv
// Register file: NREGS x DATA_W, two asynchronous read ports, one clocked
// write port; r0 is hard-wired to zero when R0_ZERO is set.
module regfile #(
  parameter int DATA_W = 8,
  parameter int NREGS = 4,
  parameter int R0_ZERO = 1,
  localparam int AW = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [AW-1:0]     raddr0,
  input  logic [AW-1:0]     raddr1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata
);

  logic [DATA_W-1:0] regs [NREGS];

  generate
    for (genvar gi = 0; gi < NREGS; gi++) begin : g_reg
      if (gi == 0 && R0_ZERO != 0) begin : g_zero
        assign regs[gi] = '0;
      end else begin : g_store
        logic [DATA_W-1:0] q_reg;
        always_ff @(posedge clk or posedge rst) begin
          if (rst) q_reg <= '0;
          else if (we && waddr == AW'(gi)) q_reg <= wdata;
        end
        assign regs[gi] = q_reg;
      end
    end
  endgenerate

  assign rdata0 = regs[raddr0];
  assign rdata1 = regs[raddr1];

endmodule

// File: rtl/multicycle_core.sv
// Parametrised multi-cycle CPU: FETCH/DECODE/EXEC/MEM/WB/HALT sequencer with
// req/ack instruction and data memory ports that tolerate wait states.
module multicycle_core
  import core_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8,
  parameter int NREGS = 4,
  parameter int IMM_W = 4,
  parameter int R0_ZERO = 1,
  localparam int REG_AW = $clog2(NREGS),
  localparam int INSTR_W = 4 + 3 * REG_AW + IMM_W
) (
  input  logic               clk,
  input  logic               rst,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               dmem_req,
  output logic               dmem_we,
  output logic [ADDR_W-1:0]  dmem_addr,
  output logic [DATA_W-1:0]  dmem_wdata,
  input  logic               dmem_ack,
  input  logic [DATA_W-1:0]  dmem_rdata,
  output logic [ADDR_W-1:0]  pc_out,
  output logic               retire,
  output logic               halted,
  output logic               ovf
);

  localparam int RS1_LSB = IMM_W;
  localparam int RS0_LSB = IMM_W + REG_AW;
  localparam int RD_LSB  = IMM_W + 2 * REG_AW;
  localparam int OP_LSB  = IMM_W + 3 * REG_AW;

  state_t              state_reg;
  logic [INSTR_W-1:0]  instr_reg;
  logic [ADDR_W-1:0]   pc_reg;
  logic [DATA_W-1:0]   op_a_reg, op_b_reg, result_reg;
  logic                imem_req_reg, dmem_req_reg, dmem_we_reg;
  logic [ADDR_W-1:0]   dmem_addr_reg;
  logic [DATA_W-1:0]   dmem_wdata_reg;
  logic                retire_reg, halted_reg, ovf_reg;

  logic [3:0]          opcode;
  logic [REG_AW-1:0]   rd_idx, rs0_idx, rs1_idx;
  logic [DATA_W-1:0]   imm_d, rdata0, rdata1, alu_res, addr_sum;
  logic [ADDR_W-1:0]   imm_a, pc_inc, pc_branch;
  logic                alu_ovf, take_branch;

  assign opcode  = 4'(get_field(64'(instr_reg), OP_LSB, 4));
  assign rd_idx  = REG_AW'(get_field(64'(instr_reg), RD_LSB, REG_AW));
  assign rs0_idx = REG_AW'(get_field(64'(instr_reg), RS0_LSB, REG_AW));
  assign rs1_idx = REG_AW'(get_field(64'(instr_reg), RS1_LSB, REG_AW));
  assign imm_d   = DATA_W'(sext(get_field(64'(instr_reg), 0, IMM_W), IMM_W));
  assign imm_a   = ADDR_W'(sext(get_field(64'(instr_reg), 0, IMM_W), IMM_W));

  regfile #(.DATA_W(DATA_W), .NREGS(NREGS), .R0_ZERO(R0_ZERO)) u_rf (
    .clk(clk), .rst(rst),
    .raddr0(rs0_idx), .raddr1(rs1_idx),
    .rdata0(rdata0), .rdata1(rdata1),
    .we(state_reg == ST_WB), .waddr(rd_idx), .wdata(result_reg)
  );

  // Overflow: operands agree in sign (after negating b for SUB) but the result does not.
  always_comb begin
    alu_res = '0;
    alu_ovf = 1'b0;
    case (opcode)
      OP_ADD: begin
        alu_res = op_a_reg + op_b_reg;
        alu_ovf = (op_a_reg[DATA_W-1] == op_b_reg[DATA_W-1]) && (alu_res[DATA_W-1] != op_a_reg[DATA_W-1]);
      end
      OP_SUB: begin
        alu_res = op_a_reg - op_b_reg;
        alu_ovf = (op_a_reg[DATA_W-1] != op_b_reg[DATA_W-1]) && (alu_res[DATA_W-1] != op_a_reg[DATA_W-1]);
      end
      OP_AND:  alu_res = op_a_reg & op_b_reg;
      OP_OR:   alu_res = op_a_reg | op_b_reg;
      OP_XOR:  alu_res = op_a_reg ^ op_b_reg;
      OP_SLT:  alu_res = {{(DATA_W-1){1'b0}}, ($signed(op_a_reg) < $signed(op_b_reg))};
      OP_ADDI: begin
        alu_res = op_a_reg + imm_d;
        alu_ovf = (op_a_reg[DATA_W-1] == imm_d[DATA_W-1]) && (alu_res[DATA_W-1] != op_a_reg[DATA_W-1]);
      end
      OP_LI:   alu_res = imm_d;
      default: alu_res = '0;
    endcase
  end

  assign addr_sum    = op_a_reg + imm_d;
  assign pc_inc      = pc_reg + ADDR_W'(1);
  assign pc_branch   = pc_inc + imm_a;
  assign take_branch = (opcode == OP_J) ||
                       (opcode == OP_BEQ && op_a_reg == op_b_reg) ||
                       (opcode == OP_BNE && op_a_reg != op_b_reg);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= ST_FETCH;
      instr_reg      <= '0;
      pc_reg         <= '0;
      op_a_reg       <= '0;
      op_b_reg       <= '0;
      result_reg     <= '0;
      imem_req_reg   <= 1'b0;
      dmem_req_reg   <= 1'b0;
      dmem_we_reg    <= 1'b0;
      dmem_addr_reg  <= '0;
      dmem_wdata_reg <= '0;
      retire_reg     <= 1'b0;
      halted_reg     <= 1'b0;
      ovf_reg        <= 1'b0;
    end else begin
      retire_reg <= 1'b0;
      case (state_reg)
        // The first cycle after reset only raises imem_req; later fetches enter with it already high.
        ST_FETCH: begin
          if (!imem_req_reg) begin
            imem_req_reg <= 1'b1;
          end else if (imem_ack) begin
            instr_reg    <= imem_rdata;
            imem_req_reg <= 1'b0;
            state_reg    <= ST_DECODE;
          end
        end
        ST_DECODE: begin
          op_a_reg  <= rdata0;
          op_b_reg  <= rdata1;
          state_reg <= ST_EXEC;
        end
        ST_EXEC: begin
          if (!opcode[3]) begin
            result_reg <= alu_res;
            if (alu_ovf) ovf_reg <= 1'b1;
            state_reg  <= ST_WB;
          end else if (opcode == OP_LW || opcode == OP_SW) begin
            dmem_req_reg   <= 1'b1;
            dmem_we_reg    <= (opcode == OP_SW);
            dmem_addr_reg  <= ADDR_W'(addr_sum);
            dmem_wdata_reg <= op_b_reg;
            state_reg      <= ST_MEM;
          end else if (opcode == OP_HALT) begin
            halted_reg <= 1'b1;
            retire_reg <= 1'b1;
            state_reg  <= ST_HALT;
          end else begin
            pc_reg       <= take_branch ? pc_branch : pc_inc;
            retire_reg   <= 1'b1;
            imem_req_reg <= 1'b1;
            state_reg    <= ST_FETCH;
          end
        end
        ST_MEM: begin
          if (dmem_ack) begin
            dmem_req_reg <= 1'b0;
            dmem_we_reg  <= 1'b0;
            if (dmem_we_reg) begin
              pc_reg       <= pc_inc;
              retire_reg   <= 1'b1;
              imem_req_reg <= 1'b1;
              state_reg    <= ST_FETCH;
            end else begin
              result_reg <= dmem_rdata;
              state_reg  <= ST_WB;
            end
          end
        end
        ST_WB: begin
          pc_reg       <= pc_inc;
          retire_reg   <= 1'b1;
          imem_req_reg <= 1'b1;
          state_reg    <= ST_FETCH;
        end
        ST_HALT: state_reg <= ST_HALT;
        default: state_reg <= ST_FETCH;
      endcase
    end
  end

  assign imem_req   = imem_req_reg;
  assign imem_addr  = pc_reg;
  assign dmem_req   = dmem_req_reg;
  assign dmem_we    = dmem_we_reg;
  assign dmem_addr  = dmem_addr_reg;
  assign dmem_wdata = dmem_wdata_reg;
  assign pc_out     = pc_reg;
  assign retire     = retire_reg;
  assign halted     = halted_reg;
  assign ovf        = ovf_reg;

endmodule

// File: tb/tb_multicycle_core.sv
// Bench for multicycle_core: wait-state memory responders plus an
// instruction-level reference model of the ISA.
module tb_multicycle_core;

  localparam int DW = 8;
  localparam int AW = 8;
  localparam int NR = 4;
  localparam int IW = 4;
  localparam int RAW = 2;
  localparam int XW = 4 + 3 * RAW + IW;
  localparam int MEMN = 1 << AW;
  localparam int DMASK = (1 << DW) - 1;
  localparam int AMASK = MEMN - 1;
  localparam int HALF = 1 << (DW - 1);

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic imem_req, imem_ack, dmem_req, dmem_we, dmem_ack, retire, halted, ovf;
  logic [AW-1:0] imem_addr, dmem_addr, pc_out;
  logic [XW-1:0] imem_rdata;
  logic [DW-1:0] dmem_wdata, dmem_rdata;

  multicycle_core #(.DATA_W(DW), .ADDR_W(AW), .NREGS(NR), .IMM_W(IW), .R0_ZERO(1)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .pc_out(pc_out), .retire(retire), .halted(halted), .ovf(ovf)
  );

  always #5 clk = ~clk;

  typedef struct {bit we; int addr; int data;} acc_t;

  logic [XW-1:0] imem [MEMN];
  logic [DW-1:0] dmem [MEMN];
  acc_t dtrace[$];
  acc_t mtrace[$];
  int i_wmin = 0, i_wmax = 0, d_wmin = 0, d_wmax = 0;
  int i_cnt = 0, d_cnt = 0, i_wait = 0, d_wait = 0;
  int stab_err = 0;
  int n_tests = 0, n_fail = 0;

  assign imem_rdata = imem[imem_addr];
  assign dmem_rdata = dmem[dmem_addr];
  assign imem_ack = imem_req && (i_cnt >= i_wait);
  assign dmem_ack = dmem_req && (d_cnt >= d_wait);

  // Memory responders: a fresh wait count is drawn while idle
  always @(posedge clk) begin
    if (!imem_req) begin
      i_cnt <= 0;
      i_wait <= $urandom_range(i_wmax, i_wmin);
    end else if (imem_ack) i_cnt <= 0;
    else i_cnt <= i_cnt + 1;
    if (!dmem_req) begin
      d_cnt <= 0;
      d_wait <= $urandom_range(d_wmax, d_wmin);
    end else if (dmem_ack) d_cnt <= 0;
    else d_cnt <= d_cnt + 1;
    if (dmem_req && dmem_ack) begin
      dtrace.push_back('{dmem_we, int'(dmem_addr), dmem_we ? int'(dmem_wdata) : int'(dmem_rdata)});
      if (dmem_we) dmem[dmem_addr] = dmem_wdata;
    end
  end

  // Request hold monitor: counts any change of a pending request before its ack
  logic hold_i = 1'b0, hold_d = 1'b0, h_we = 1'b0;
  logic [AW-1:0] h_iaddr = '0, h_daddr = '0;
  logic [DW-1:0] h_wdata = '0;
  always @(posedge clk) begin
    if (!rst && hold_i && (imem_req !== 1'b1 || imem_addr !== h_iaddr)) stab_err = stab_err + 1;
    if (!rst && hold_d && (dmem_req !== 1'b1 || dmem_addr !== h_daddr || dmem_we !== h_we || dmem_wdata !== h_wdata))
      stab_err = stab_err + 1;
    hold_i  <= imem_req && !imem_ack;
    h_iaddr <= imem_addr;
    hold_d  <= dmem_req && !dmem_ack;
    h_daddr <= dmem_addr;
    h_we    <= dmem_we;
    h_wdata <= dmem_wdata;
  end

  // ---------------- reference model ----------------
  int m_regs[NR];
  int m_mem[MEMN];
  bit m_ovf, m_halted;
  int m_pc, m_retires, m_cycles;

  function automatic int sx(input int v, input int w);
    return (v >= (1 << (w - 1))) ? v - (1 << w) : v;
  endfunction

  function automatic logic [XW-1:0] enc(input int op, input int rd, input int rs0, input int rs1, input int imm);
    return XW'((op << (IW + 3 * RAW)) | ((rd & (NR - 1)) << (IW + 2 * RAW)) |
               ((rs0 & (NR - 1)) << (IW + RAW)) | ((rs1 & (NR - 1)) << IW) | (imm & ((1 << IW) - 1)));
  endfunction

  task automatic model_run();
    int w, op, rd, rs0, rs1, imm, a, b, sa, sb, sres, val, addr, nxt;
    for (int i = 0; i < NR; i++) m_regs[i] = 0;
    for (int i = 0; i < MEMN; i++) m_mem[i] = int'(dmem[i]);
    mtrace.delete();
    m_pc = 0; m_ovf = 0; m_halted = 0; m_retires = 0; m_cycles = 1;
    for (int step = 0; step < 4000 && !m_halted; step++) begin
      w = int'(imem[m_pc]);
      op = (w >> (IW + 3 * RAW)) & 15;
      rd = (w >> (IW + 2 * RAW)) & (NR - 1);
      rs0 = (w >> (IW + RAW)) & (NR - 1);
      rs1 = (w >> IW) & (NR - 1);
      imm = sx(w & ((1 << IW) - 1), IW);
      a = m_regs[rs0]; b = m_regs[rs1];
      sa = sx(a, DW); sb = sx(b, DW);
      nxt = (m_pc + 1) & AMASK;
      sres = 0; val = 0;
      if (op < 8) begin
        case (op)
          0: sres = sa + sb;
          1: sres = sa - sb;
          2: val = a & b;
          3: val = a | b;
          4: val = a ^ b;
          5: val = (sa < sb) ? 1 : 0;
          6: sres = sa + imm;
          default: val = imm & DMASK;
        endcase
        if (op == 0 || op == 1 || op == 6) begin
          if (sres > HALF - 1 || sres < -HALF) m_ovf = 1;
          val = sres & DMASK;
        end
        if (rd != 0) m_regs[rd] = val;
        m_pc = nxt; m_cycles += 4;
      end else if (op == 10 || op == 11) begin
        addr = ((a + imm) & DMASK) & AMASK;
        if (op == 10) begin
          val = m_mem[addr];
          if (rd != 0) m_regs[rd] = val;
          mtrace.push_back('{1'b0, addr, val});
          m_cycles += 5;
        end else begin
          m_mem[addr] = b;
          mtrace.push_back('{1'b1, addr, b});
          m_cycles += 4;
        end
        m_pc = nxt;
      end else begin
        if ((op == 12 && a == b) || (op == 13 && a != b) || op == 14) m_pc = (m_pc + 1 + imm) & AMASK;
        else if (op == 15) m_halted = 1;
        else m_pc = nxt;
        m_cycles += 3;
      end
      m_retires++;
    end
  endtask

  // ---------------- run helpers (observation only) ----------------
  int obs_cycles, obs_retires;
  bit obs_done;
  int ret_at[$];

  task automatic run_prog(input int max_cyc);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    dtrace.delete();
    stab_err = 0;
    ret_at.delete();
    obs_cycles = 0; obs_retires = 0; obs_done = 0;
    rst = 1'b0;
    while (obs_cycles < max_cyc && !obs_done) begin
      @(posedge clk);
      obs_cycles++;
      @(negedge clk);
      if (retire) begin
        obs_retires++;
        ret_at.push_back(obs_cycles);
      end
      if (halted) obs_done = 1;
    end
  endtask

  task automatic clear_imem();
    for (int i = 0; i < MEMN; i++) imem[i] = enc(15, 0, 0, 0, 0);
  endtask

  task automatic clear_dmem();
    for (int i = 0; i < MEMN; i++) dmem[i] = '0;
  endtask

  function automatic int mem_diff();
    for (int i = 0; i < MEMN; i++) if (int'(dmem[i]) != m_mem[i]) return i;
    return -1;
  endfunction

  function automatic int trace_diff();
    if (dtrace.size() != mtrace.size()) return 9999;
    for (int i = 0; i < dtrace.size(); i++)
      if (dtrace[i].we != mtrace[i].we || dtrace[i].addr != mtrace[i].addr || dtrace[i].data != mtrace[i].data) return i;
    return -1;
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    clear_imem(); clear_dmem();
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    n_tests++;
    if ({imem_req, dmem_req, dmem_we, retire, halted, ovf} !== 6'b0) begin
      n_fail++; $display("FAIL reset_outs: got %b expected 000000", {imem_req, dmem_req, dmem_we, retire, halted, ovf});
    end
    n_tests++;
    if (pc_out !== '0) begin n_fail++; $display("FAIL reset_pc: got %0d expected 0", pc_out); end
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_tests++;
    if (imem_req !== 1'b0) begin n_fail++; $display("FAIL req_before_clk: got %b expected 0", imem_req); end
    @(posedge clk); #1;
    n_tests++;
    if (imem_req !== 1'b1 || imem_addr !== '0) begin
      n_fail++; $display("FAIL req_first_clk: got req=%b addr=%0d expected req=1 addr=0", imem_req, imem_addr);
    end
    $display("[TB] reset: outputs zero, fetch from 0 after first clock");
  endtask

  task automatic test_basic_alu();
    i_wmin = 0; i_wmax = 0; d_wmin = 0; d_wmax = 0;
    clear_imem(); clear_dmem();
    imem[0] = enc(7, 1, 0, 0, 3);
    imem[1] = enc(7, 2, 0, 0, -2);
    imem[2] = enc(0, 3, 1, 2, 0);
    imem[3] = enc(11, 0, 0, 3, 0);
    model_run();
    run_prog(500);
    n_tests++;
    if (!obs_done || obs_cycles != m_cycles) begin
      n_fail++; $display("FAIL basic_cycles: got done=%0d cycles=%0d expected cycles=%0d", obs_done, obs_cycles, m_cycles);
    end
    n_tests++;
    if (int'(dmem[0]) != 1) begin n_fail++; $display("FAIL basic_r3: got %0d expected 1", dmem[0]); end
    n_tests++;
    if (obs_retires != m_retires || int'(pc_out) != m_pc) begin
      n_fail++; $display("FAIL basic_retire_pc: got ret=%0d pc=%0d expected ret=%0d pc=%0d", obs_retires, pc_out, m_retires, m_pc);
    end
    n_tests++;
    if (ret_at.size() >= 3 && (ret_at[1] - ret_at[0] != 4 || ret_at[2] - ret_at[1] != 4)) begin
      n_fail++; $display("FAIL alu_latency: got %0d/%0d expected 4/4", ret_at[1] - ret_at[0], ret_at[2] - ret_at[1]);
    end
    $display("[TB] basic: cycles=%0d retires=%0d mem0=%0d", obs_cycles, obs_retires, dmem[0]);
  endtask

  task automatic test_mem_wait();
    i_wmin = 0; i_wmax = 0; d_wmin = 2; d_wmax = 2;
    clear_imem(); clear_dmem();
    imem[0] = enc(7, 1, 0, 0, 7);
    imem[1] = enc(11, 0, 0, 1, 2);
    imem[2] = enc(10, 2, 0, 0, 2);
    imem[3] = enc(11, 0, 0, 2, 3);
    model_run();
    run_prog(500);
    n_tests++;
    if (!obs_done || dmem[2] !== 8'd7 || dmem[3] !== 8'd7) begin
      n_fail++; $display("FAIL lw_sw_data: got done=%0d m2=%0d m3=%0d expected 7/7", obs_done, dmem[2], dmem[3]);
    end
    n_tests++;
    if (ret_at.size() < 3 || ret_at[1] - ret_at[0] != 6 || ret_at[2] - ret_at[1] != 7) begin
      n_fail++; $display("FAIL mem_latency: got %0d retires expected SW=6 LW=7 cycle spacing", ret_at.size());
    end
    n_tests++;
    if (stab_err != 0) begin n_fail++; $display("FAIL req_hold: got %0d violations expected 0", stab_err); end
    n_tests++;
    if (trace_diff() != -1) begin n_fail++; $display("FAIL mem_trace: first diff at %0d expected none", trace_diff()); end
    $display("[TB] mem_wait: m2=%0d m3=%0d accesses=%0d", dmem[2], dmem[3], dtrace.size());
  endtask

  task automatic test_branch();
    i_wmin = 0; i_wmax = 0; d_wmin = 0; d_wmax = 0;
    clear_imem(); clear_dmem();
    imem[0] = enc(7, 1, 0, 0, 1);
    imem[1] = enc(7, 2, 0, 0, 1);
    imem[2] = enc(12, 0, 1, 2, -1);
    run_prog(60);
    n_tests++;
    if (obs_done || pc_out !== 8'd2 || obs_retires < 10) begin
      n_fail++; $display("FAIL beq_loop: got halted=%0d pc=%0d ret=%0d expected 0/2/>=10", obs_done, pc_out, obs_retires);
    end
    imem[2] = enc(13, 0, 1, 2, -1);
    imem[3] = enc(11, 0, 0, 1, 4);
    model_run();
    run_prog(500);
    n_tests++;
    if (!obs_done || int'(pc_out) != m_pc || dmem[4] !== 8'd1) begin
      n_fail++; $display("FAIL bne_fall: got pc=%0d m4=%0d expected pc=%0d m4=1", pc_out, dmem[4], m_pc);
    end
    clear_imem(); clear_dmem();
    imem[0] = enc(13, 0, 3, 0, 1);
    imem[1] = enc(14, 0, 0, 0, -3);
    imem[2] = enc(11, 0, 0, 3, 1);
    imem[255] = enc(7, 3, 0, 0, 5);
    model_run();
    run_prog(500);
    n_tests++;
    if (!obs_done || pc_out !== 8'd3 || dmem[1] !== 8'd5 || obs_retires != m_retires) begin
      n_fail++; $display("FAIL pc_wrap: got pc=%0d m1=%0d ret=%0d expected 3/5/%0d", pc_out, dmem[1], obs_retires, m_retires);
    end
    $display("[TB] branch: wrap run pc=%0d retires=%0d", pc_out, obs_retires);
  endtask

  task automatic test_ovf();
    i_wmin = 0; i_wmax = 1; d_wmin = 0; d_wmax = 1;
    for (int n = 120; n <= 121; n++) begin
      clear_imem(); clear_dmem();
      imem[0] = enc(7, 1, 0, 0, 7);
      for (int k = 1; k <= n; k++) imem[k] = enc(6, 1, 1, 0, 1);
      imem[n + 1] = enc(0, 2, 1, 0, 0);
      imem[n + 2] = enc(7, 3, 0, 0, 1);
      imem[n + 3] = enc(11, 0, 0, 1, 0);
      model_run();
      run_prog(3000);
      n_tests++;
      if (!obs_done || ovf !== (n == 121) || dmem[0] !== 8'(7 + n)) begin
        n_fail++; $display("FAIL ovf_n%0d: got ovf=%b r1=%0d expected ovf=%0d r1=%0d", n, ovf, dmem[0], n == 121, 7 + n);
      end
      n_tests++;
      if (ovf !== m_ovf || mem_diff() != -1) begin
        n_fail++; $display("FAIL ovf_model_n%0d: got ovf=%b diff=%0d expected ovf=%0d diff=-1", n, ovf, mem_diff(), m_ovf);
      end
      $display("[TB] ovf: n=%0d r1=0x%h ovf=%b", n, dmem[0], ovf);
    end
  endtask

  task automatic test_reset_mid_mem();
    int guard;
    i_wmin = 0; i_wmax = 0; d_wmin = 10; d_wmax = 10;
    clear_imem(); clear_dmem();
    imem[0] = enc(7, 1, 0, 0, 7);
    imem[1] = enc(11, 0, 0, 1, 2);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    guard = 0;
    while (dmem_req !== 1'b1 && guard < 40) begin @(negedge clk); guard++; end
    n_tests++;
    if (dmem_req !== 1'b1) begin n_fail++; $display("FAIL mid_wait: got no dmem_req in 40 cycles expected one"); end
    #2 rst = 1'b1;
    #1;
    n_tests++;
    if ({dmem_req, retire, halted, imem_req} !== 4'b0 || pc_out !== '0) begin
      n_fail++; $display("FAIL mid_rst_outs: got req=%b ret=%b hlt=%b pc=%0d expected zeros", dmem_req, retire, halted, pc_out);
    end
    clear_imem();
    imem[0] = enc(11, 0, 0, 1, 5);
    dmem[5] = 8'hAA;
    d_wmin = 0; d_wmax = 0;
    model_run();
    run_prog(500);
    n_tests++;
    if (!obs_done || dmem[5] !== 8'h00 || dmem[2] !== 8'h00 || int'(pc_out) != m_pc) begin
      n_fail++; $display("FAIL mid_rst_state: got m5=%0d m2=%0d pc=%0d expected 0/0/%0d", dmem[5], dmem[2], pc_out, m_pc);
    end
    $display("[TB] reset_mid_mem: restarted, pc=%0d m5=%0d", pc_out, dmem[5]);
  endtask

  task automatic test_r0_zero();
    i_wmin = 0; i_wmax = 0; d_wmin = 0; d_wmax = 0;
    clear_imem(); clear_dmem();
    dmem[1] = 8'hFF;
    imem[0] = enc(7, 0, 0, 0, 5);
    imem[1] = enc(11, 0, 0, 0, 1);
    run_prog(500);
    n_tests++;
    if (!obs_done || dmem[1] !== 8'h00) begin n_fail++; $display("FAIL r0_zero: got %0d expected 0", dmem[1]); end
    $display("[TB] r0_zero: stored r0=%0d", dmem[1]);
  endtask

  task automatic test_random();
    int op;
    for (int it = 0; it < 10; it++) begin
      i_wmin = 0; i_wmax = it % 2; d_wmin = 0; d_wmax = it % 3;
      clear_imem();
      for (int i = 0; i < MEMN; i++) dmem[i] = DW'($urandom);
      for (int i = 0; i < 24; i++) begin
        op = $urandom_range(14, 0);
        if (op >= 12) imem[i] = enc(op, $urandom, $urandom, $urandom, $urandom_range(7, 0));
        else imem[i] = enc(op, $urandom, $urandom, $urandom, $urandom);
      end
      for (int r = 1; r < NR; r++) imem[23 + r] = enc(11, 0, 0, r, -r);
      model_run();
      run_prog(3000);
      n_tests++;
      if (!obs_done || obs_retires != m_retires || int'(pc_out) != m_pc) begin
        n_fail++; $display("FAIL rnd%0d_flow: got done=%0d ret=%0d pc=%0d expected ret=%0d pc=%0d", it, obs_done, obs_retires, pc_out, m_retires, m_pc);
      end
      n_tests++;
      if (ovf !== m_ovf) begin n_fail++; $display("FAIL rnd%0d_ovf: got %b expected %0d", it, ovf, m_ovf); end
      n_tests++;
      if (mem_diff() != -1) begin n_fail++; $display("FAIL rnd%0d_mem: first diff addr %0d expected none", it, mem_diff()); end
      n_tests++;
      if (trace_diff() != -1) begin n_fail++; $display("FAIL rnd%0d_trace: first diff %0d expected none", it, trace_diff()); end
      n_tests++;
      if (stab_err != 0) begin n_fail++; $display("FAIL rnd%0d_hold: got %0d expected 0", it, stab_err); end
      $display("[TB] random %0d: retires=%0d accesses=%0d cycles=%0d", it, obs_retires, dtrace.size(), obs_cycles);
    end
  endtask

  initial begin
    test_reset();
    test_basic_alu();
    test_mem_wait();
    test_branch();
    test_ovf();
    test_reset_mid_mem();
    test_r0_zero();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
